// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one outstanding miss.
// Ports:
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global ready; low freezes every register
//   fetch_valid/pc/ready      fetch request from the IFU
//   flush                     discard undelivered fetches
//   inst_valid/out/pc         one-cycle delivery pulse to the IFU
//   icache_req/addr           miss request to the memory controller
//   mem_received/task_out     controller accept / data-return strobes
//   mem_value                 returned instruction word
module icache #(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        mem_received,
  input  logic        mem_task_out,
  input  logic [31:0] mem_value
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [31:0]             data_q [LINES];
  logic [31:0]             pc_q, pc_d;
  logic                    discard_q, discard_d;
  logic                    req_d, iv_d;
  logic [31:0]             addr_d, io_d, ip_d;
  logic                    fill_we;

  // Fetch-side lookup; the byte offset is masked off so every PC bit is consumed.
  logic [31:0]             aligned_pc_c;
  logic [INDEX_BITS-1:0]   fetch_idx_c, fill_idx_c;
  logic [TAG_W-1:0]        fetch_tag_c;
  logic                    hit_c, done_c;

  assign aligned_pc_c = fetch_pc & 32'hFFFF_FFFC;
  assign fetch_idx_c  = aligned_pc_c[INDEX_BITS+1:2];
  assign fetch_tag_c  = aligned_pc_c[31:INDEX_BITS+2];
  assign fill_idx_c   = pc_q[INDEX_BITS+1:2];
  assign hit_c        = valid_q[fetch_idx_c] && (tag_q[fetch_idx_c] == fetch_tag_c);

  // Data return completes the miss in WAIT, or in REQ when accept and data coincide.
  assign done_c = mem_task_out &&
                  ((state_q == S_WAIT) || ((state_q == S_REQ) && mem_received));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    req_d     = icache_req;
    addr_d    = icache_addr;
    iv_d      = inst_valid;
    io_d      = inst_out;
    ip_d      = inst_pc;
    fill_we   = 1'b0;
    if (rdy_in) begin
      iv_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_valid && !flush) begin
            if (hit_c) begin
              iv_d = 1'b1;
              io_d = data_q[fetch_idx_c];
              ip_d = aligned_pc_c;
            end else begin
              pc_d      = aligned_pc_c;
              addr_d    = aligned_pc_c;
              req_d     = 1'b1;
              discard_d = 1'b0;
              state_d   = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) discard_d = 1'b1;
          if (mem_received) begin
            req_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) discard_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      if (done_c) begin
        fill_we = 1'b1;
        // A flush in the delivery cycle itself also suppresses the pulse.
        if (!(discard_q || flush)) begin
          iv_d = 1'b1;
          io_d = mem_value;
          ip_d = pc_q;
        end
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
    end
  end

  // Control, outputs and valid bits.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      pc_q        <= 32'd0;
      discard_q   <= 1'b0;
      icache_req  <= 1'b0;
      icache_addr <= 32'd0;
      inst_valid  <= 1'b0;
      inst_out    <= 32'd0;
      inst_pc     <= 32'd0;
      fetch_ready <= 1'b1;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      icache_req  <= req_d;
      icache_addr <= addr_d;
      inst_valid  <= iv_d;
      inst_out    <= io_d;
      inst_pc     <= ip_d;
      fetch_ready <= (state_d == S_IDLE);
      if (fill_we) valid_q[fill_idx_c] <= 1'b1;
    end
  end

  // Tag and data arrays; qualified by the valid bits, so no reset.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_q[fill_idx_c]  <= pc_q[31:INDEX_BITS+2];
      data_q[fill_idx_c] <= mem_value;
    end
  end

endmodule
